config_frame_loader: RTL and testbench

Bitstream-to-frame write controller in the fabric configuration path. It consumes a stream of 32-bit configuration words and detects the sync header. It assembles one frame's worth of row data, then issues a single-cycle frame write strobe with column and frame select. Those strobes load the per-tile frame latches whose ConfigBits feed tile primitives and config-access outputs.

---
 rtl/config_frame_loader_if.sv | 28 ++
 rtl/config_frame_loader.sv | 138 +++++++++++++
 tb/tb_config_frame_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/config_frame_loader_if.sv
// Configuration word stream in, assembled frame and frame-write controls out.
interface config_frame_loader_if #(
    parameter int unsigned NumberOfRows    = 16,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumberOfCols    = 16
);
    logic [31:0]                             WriteData;
    logic                                    WriteStrobe;
    logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData;
    logic [NumberOfCols-1:0]                 ColumnSelect;
    logic [MaxFramesPerCol-1:0]              FrameSelect;
    logic                                    FrameStrobe;
    logic                                    Synced;
    logic                                    Error;

    // Bitstream source side.
    modport master (
        output WriteData, WriteStrobe,
        input  FrameData, ColumnSelect, FrameSelect, FrameStrobe, Synced, Error
    );

    // Frame loader side.
    modport slave (
        input  WriteData, WriteStrobe,
        output FrameData, ColumnSelect, FrameSelect, FrameStrobe, Synced, Error
    );
endinterface

// File: rtl/config_frame_loader.sv
// Bitstream-to-frame write controller: finds the sync header, decodes a
// column/frame command, gathers one word per row and pulses FrameStrobe.
module config_frame_loader #(
    parameter int unsigned NumberOfRows    = 16,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumberOfCols    = 16,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter int unsigned DesyncFlag      = 20
) (
    input  logic                  CLK,
    input  logic                  resetn,
    config_frame_loader_if.slave  bus
);
    localparam int unsigned RowCntW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int unsigned FrameW  = NumberOfRows * FrameBitsPerRow;
    localparam logic [RowCntW-1:0] LastRow = RowCntW'(NumberOfRows - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNCED = 2'd1,
        DATA   = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [RowCntW-1:0]          row_q, row_d;
    logic [FrameW-1:0]           frame_q;
    logic [NumberOfCols-1:0]     col_sel_q, col_sel_d;
    logic [MaxFramesPerCol-1:0]  frm_sel_q, frm_sel_d;
    logic                        valid_q, valid_d;
    logic                        error_q, error_d;
    logic                        strobe_q, strobe_d;
    logic                        synced_q;
    logic                        row_we_c;

    logic [7:0] cmd_col_c;
    logic [4:0] cmd_frm_c;
    logic       cmd_ok_c;
    logic       is_sync_c;

    // Command field decode and range check.
    assign cmd_col_c = bus.WriteData[31:24];
    assign cmd_frm_c = bus.WriteData[4:0];
    assign cmd_ok_c  = (32'(cmd_col_c) < NumberOfCols) && (32'(cmd_frm_c) < MaxFramesPerCol);
    assign is_sync_c = (bus.WriteData == SyncWord);

    // Next-state and control decode; idle cycles only drop the strobe.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_sel_d = col_sel_q;
        frm_sel_d = frm_sel_q;
        valid_d   = valid_q;
        error_d   = error_q;
        strobe_d  = 1'b0;
        row_we_c  = 1'b0;
        if (bus.WriteStrobe) begin
            case (state_q)
                IDLE: begin
                    if (is_sync_c) state_d = SYNCED;
                end
                SYNCED: begin
                    // The sync word has the desync bit set, so re-sync is matched first.
                    if (is_sync_c) begin
                        state_d = SYNCED;
                    end else if (bus.WriteData[DesyncFlag]) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        row_d   = '0;
                        if (cmd_ok_c) begin
                            col_sel_d = NumberOfCols'(1) << cmd_col_c;
                            frm_sel_d = MaxFramesPerCol'(1) << cmd_frm_c;
                            valid_d   = 1'b1;
                        end else begin
                            error_d = 1'b1;
                            valid_d = 1'b0;
                        end
                    end
                end
                DATA: begin
                    row_we_c = 1'b1;
                    if (row_q == LastRow) begin
                        state_d  = SYNCED;
                        row_d    = '0;
                        strobe_d = valid_q;
                    end else begin
                        row_d = row_q + RowCntW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_sel_q <= '0;
            frm_sel_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            strobe_q  <= 1'b0;
            synced_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_sel_q <= col_sel_d;
            frm_sel_q <= frm_sel_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            strobe_q  <= strobe_d;
            synced_q  <= (state_d != IDLE);
        end
    end

    // Row data capture into the frame buffer.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            frame_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NumberOfRows; r++) begin
                if (row_we_c && (row_q == RowCntW'(r))) begin
                    frame_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= FrameBitsPerRow'(bus.WriteData);
                end
            end
        end
    end

    assign bus.FrameData    = frame_q;
    assign bus.ColumnSelect = col_sel_q;
    assign bus.FrameSelect  = frm_sel_q;
    assign bus.FrameStrobe  = strobe_q;
    assign bus.Synced       = synced_q;
    assign bus.Error        = error_q;
endmodule

// File: tb/tb_config_frame_loader.sv
// Randomised and directed stimulus for config_frame_loader against a word-level reference model.
module tb_config_frame_loader;
    localparam int unsigned Rows  = 16;
    localparam int unsigned Frms  = 20;
    localparam int unsigned Cols  = 16;
    localparam logic [31:0] SYNC  = 32'hFAB0_FAB1;

    logic clk;
    logic rst_n;

    config_frame_loader_if #(
        .NumberOfRows(Rows), .FrameBitsPerRow(32), .MaxFramesPerCol(Frms), .NumberOfCols(Cols)
    ) bus ();

    config_frame_loader #(
        .NumberOfRows(Rows), .FrameBitsPerRow(32), .MaxFramesPerCol(Frms),
        .NumberOfCols(Cols), .SyncWord(SYNC), .DesyncFlag(20)
    ) dut (
        .CLK    (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int dut_strobes;

    // Reference model: stream position expressed as "words still owed to the frame".
    bit          m_synced;
    bit          m_err;
    bit          m_ok;
    bit          m_strobe;
    int          m_left;
    int          m_col;
    int          m_frm;
    logic [31:0] m_frame [Rows];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_err = 0; m_ok = 0; m_strobe = 0;
        m_left = 0; m_col = -1; m_frm = -1;
        for (int r = 0; r < Rows; r++) m_frame[r] = '0;
    endtask

    task automatic model_step(input bit stb, input logic [31:0] d);
        int col;
        int frm;
        m_strobe = 0;
        if (!stb) return;
        if (!m_synced) begin
            if (d == SYNC) m_synced = 1;
        end else if (m_left == 0) begin
            if (d == SYNC) begin
                m_synced = 1;
            end else if (d[20]) begin
                m_synced = 0;
            end else begin
                col = int'(d[31:24]);
                frm = int'(d[4:0]);
                if (col < Cols && frm < Frms) begin
                    m_col = col; m_frm = frm; m_ok = 1;
                end else begin
                    m_err = 1; m_ok = 0;
                end
                m_left = Rows;
            end
        end else begin
            m_frame[Rows - m_left] = d;
            m_left--;
            if (m_left == 0 && m_ok) m_strobe = 1;
        end
    endtask

    task automatic check_all(input string ctx);
        logic [Rows*32-1:0] exp_fd;
        logic [Cols-1:0]    exp_col;
        logic [Frms-1:0]    exp_frm;
        exp_col = '0;
        exp_frm = '0;
        if (m_col >= 0) exp_col = Cols'(1) << m_col;
        if (m_frm >= 0) exp_frm = Frms'(1) << m_frm;
        for (int r = 0; r < Rows; r++) exp_fd[r*32 +: 32] = m_frame[r];
        check({ctx, ".synced"}, 512'(bus.Synced), 512'(m_synced));
        check({ctx, ".error"},  512'(bus.Error), 512'(m_err));
        check({ctx, ".strobe"}, 512'(bus.FrameStrobe), 512'(m_strobe));
        check({ctx, ".colsel"}, 512'(bus.ColumnSelect), 512'(exp_col));
        check({ctx, ".frmsel"}, 512'(bus.FrameSelect), 512'(exp_frm));
        check({ctx, ".framedata"}, 512'(bus.FrameData), 512'(exp_fd));
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, sample 1 later.
    task automatic cycle(input bit stb, input logic [31:0] d, input string ctx);
        @(negedge clk);
        bus.WriteStrobe = stb;
        bus.WriteData   = stb ? d : 32'($urandom);
        @(posedge clk);
        model_step(stb, d);
        #1;
        if (bus.FrameStrobe) dut_strobes++;
        check_all(ctx);
    endtask

    task automatic send(input logic [31:0] d, input bit gaps, input string ctx);
        if (gaps) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, ctx);
        end
        cycle(1'b1, d, ctx);
    endtask

    task automatic send_frame(input logic [31:0] cmd, input logic [31:0] base, input bit gaps, input string ctx);
        send(cmd, gaps, ctx);
        for (int r = 0; r < Rows; r++) send(base + 32'(r), gaps, ctx);
    endtask

    task automatic apply_reset(input string ctx);
        @(negedge clk);
        bus.WriteStrobe = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(ctx);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int sel;
        w   = 32'($urandom);
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
            w = SYNC;
        end else if (sel <= 3) begin
            w[31:24] = 8'($urandom_range(0, 19));
            w[4:0]   = 5'($urandom_range(0, 24));
            w[20]    = ($urandom_range(0, 7) == 0);
        end
        return w;
    endfunction

    initial begin
        n_checks = 0; n_fail = 0; dut_strobes = 0;
        bus.WriteStrobe = 1'b0;
        bus.WriteData   = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic back-to-back frame.
        dut_strobes = 0;
        send(SYNC, 0, "basic");
        send_frame(32'h0300_0005, 32'h1000_0000, 0, "basic");
        check("basic.strobe_seen", 512'(dut_strobes), 512'(1));
        check("basic.colsel_val", 512'(bus.ColumnSelect), 512'(16'h0008));
        cycle(1'b0, 32'h0, "basic.after");
        check("basic.strobe_once", 512'(dut_strobes), 512'(1));

        // Pre-sync garbage with random gaps.
        apply_reset("reset2");
        dut_strobes = 0;
        for (int i = 0; i < 3; i++) send(32'hDEAD_BEEF, 1, "garbage");
        check("garbage.no_strobe", 512'(dut_strobes), 512'(0));
        send(SYNC, 1, "gaps");
        send_frame(32'h0300_0005, 32'h1000_0000, 1, "gaps");
        check("gaps.row15", 512'(bus.FrameData[15*32 +: 32]), 512'(32'h1000_000F));

        // Invalid command then a valid frame.
        dut_strobes = 0;
        send_frame(32'h0000_0019, 32'h2000_0000, 0, "badcmd");
        check("badcmd.no_strobe", 512'(dut_strobes), 512'(0));
        send_frame(32'h0000_0000, 32'h3000_0000, 0, "goodcmd");
        cycle(1'b0, 32'h0, "goodcmd.after");
        check("goodcmd.strobe", 512'(dut_strobes), 512'(1));
        check("goodcmd.error_sticky", 512'(bus.Error), 512'(1));

        // Sync word as row 7, then desync.
        dut_strobes = 0;
        send(32'h0500_0002, 0, "syncdata");
        for (int r = 0; r < Rows; r++) send((r == 7) ? SYNC : 32'h4000_0000 + 32'(r), 0, "syncdata");
        check("syncdata.row7", 512'(bus.FrameData[7*32 +: 32]), 512'(SYNC));
        send(32'h0010_0000, 0, "desync");
        check("desync.synced", 512'(bus.Synced), 512'(0));
        for (int r = 0; r < Rows; r++) send(32'h5000_0000 + 32'(r), 0, "desync");
        cycle(1'b0, 32'h0, "desync.after");
        check("desync.strobes", 512'(dut_strobes), 512'(1));

        // Reset mid-frame.
        send(SYNC, 0, "midrst");
        send(32'h0100_0001, 0, "midrst");
        for (int r = 0; r < 8; r++) send(32'h6000_0000 + 32'(r), 0, "midrst");
        dut_strobes = 0;
        apply_reset("midrst.reset");
        for (int r = 8; r < Rows; r++) send(32'h6000_0000 + 32'(r), 0, "midrst.rest");
        cycle(1'b0, 32'h0, "midrst.rest");
        check("midrst.no_strobe", 512'(dut_strobes), 512'(0));
        send(SYNC, 0, "midrst.resync");
        send_frame(32'h0F00_0013, 32'h7000_0000, 0, "midrst.resync");

        // Random stream.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_word(), "random");
            if (i == 1500) apply_reset("random.reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
